// File: rtl/pll_reconfig_seq.sv
// pll_reconfig_seq
// Programs one of NUM_PROFILES stored PLL frequency profiles (N, M, K, C counters)
// through the PLL reconfig core's Avalon-MM slave, starts reconfiguration, then
// qualifies lock on the 2-flop synchronised pll_locked input.
// Optional feature macro: PLL_RECFG_READBACK_EN adds a read-back check of the
// N, M and K registers before the start write is issued.
module pll_reconfig_seq #(
    parameter int NUM_CLOCKS   = 1,
    parameter int NUM_PROFILES = 4,
    parameter logic [16*NUM_PROFILES-1:0]            N_TABLE = {NUM_PROFILES{16'h0202}},
    parameter logic [16*NUM_PROFILES-1:0]            M_TABLE = {NUM_PROFILES{16'h3838}},
    parameter logic [32*NUM_PROFILES-1:0]            K_TABLE = {NUM_PROFILES{32'd214748365}},
    parameter logic [16*NUM_PROFILES*NUM_CLOCKS-1:0] C_TABLE = {(NUM_PROFILES*NUM_CLOCKS){16'h0202}},
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 65535,
    localparam int PROF_W = $clog2(NUM_PROFILES)
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [PROF_W-1:0] req_profile,
    output logic              req_ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [PROF_W-1:0] cur_profile,
    input  logic              pll_locked,
    output logic [5:0]        mgmt_address,
    output logic [31:0]       mgmt_writedata,
    output logic              mgmt_write,
    output logic              mgmt_read,
    input  logic [31:0]       mgmt_readdata,
    input  logic              mgmt_waitrequest
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_MODE   = 4'd1;
    localparam logic [3:0] S_WR_N      = 4'd2;
    localparam logic [3:0] S_WR_M      = 4'd3;
    localparam logic [3:0] S_WR_K      = 4'd4;
    localparam logic [3:0] S_WR_C      = 4'd5;
`ifdef PLL_RECFG_READBACK_EN
    localparam logic [3:0] S_RD_CHK    = 4'd6;
`endif
    localparam logic [3:0] S_WR_START  = 4'd7;
    localparam logic [3:0] S_WAIT_LOCK = 4'd8;
    localparam logic [3:0] S_DONE      = 4'd9;
    localparam logic [3:0] S_ERR       = 4'd10;

    logic [3:0]        state;
    logic [PROF_W-1:0] prof_q;
    logic [4:0]        c_idx;
    logic              lock_meta;
    logic              lock_sync;
    logic [31:0]       stable_cnt;
    logic [31:0]       timeout_cnt;
    logic [31:0]       stable_inc;
    logic [31:0]       timeout_inc;
    logic [15:0]       n_sel;
    logic [15:0]       m_sel;
    logic [15:0]       c_sel;
    logic [31:0]       k_sel;
    logic [31:0]       n_word;
    logic [31:0]       m_word;
    logic [31:0]       c_word;
    logic              last_clock;
    logic              rd_strobe;

    // A counter of {hi,lo} = {1,1} is programmed as bypass; odd-division is never used
    function automatic logic [31:0] counter_word(input logic [15:0] hl);
        return {14'b0, 1'b0, (hl == 16'h0101), hl};
    endfunction

    assign stable_inc  = stable_cnt + 32'd1;
    assign timeout_inc = timeout_cnt + 32'd1;
    assign last_clock  = (c_idx == 5'(NUM_CLOCKS - 1));

    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);

    // Select the active profile's counter values from the parameter tables
    always_comb begin
        n_sel  = N_TABLE[16*int'(prof_q) +: 16];
        m_sel  = M_TABLE[16*int'(prof_q) +: 16];
        k_sel  = K_TABLE[32*int'(prof_q) +: 32];
        c_sel  = C_TABLE[16*(int'(prof_q)*NUM_CLOCKS + int'(c_idx)) +: 16];
        n_word = counter_word(n_sel);
        m_word = counter_word(m_sel);
        c_word = {9'b0, c_idx, 1'b0, (c_sel == 16'h0101), c_sel};
    end

`ifdef PLL_RECFG_READBACK_EN
    logic [1:0]  rd_idx;
    logic [5:0]  rd_addr;
    logic [31:0] rd_exp;

    // Read-back walks N, M, K in order and compares against what was written
    always_comb begin
        case (rd_idx)
            2'd0:    begin rd_addr = 6'h03; rd_exp = n_word; end
            2'd1:    begin rd_addr = 6'h04; rd_exp = m_word; end
            default: begin rd_addr = 6'h07; rd_exp = k_sel;  end
        endcase
    end

    assign mgmt_read = rd_strobe;
`else
    logic unused_readdata;
    assign unused_readdata = ^mgmt_readdata;
    assign mgmt_read = 1'b0;
`endif

    // Bus outputs are decoded from the state so they stay put while the slave stalls
    always_comb begin
        mgmt_address   = 6'h00;
        mgmt_writedata = 32'h0;
        mgmt_write     = 1'b0;
        rd_strobe      = 1'b0;
        case (state)
            S_WR_MODE:  begin mgmt_address = 6'h00; mgmt_writedata = 32'h0;  mgmt_write = 1'b1; end
            S_WR_N:     begin mgmt_address = 6'h03; mgmt_writedata = n_word; mgmt_write = 1'b1; end
            S_WR_M:     begin mgmt_address = 6'h04; mgmt_writedata = m_word; mgmt_write = 1'b1; end
            S_WR_K:     begin mgmt_address = 6'h07; mgmt_writedata = k_sel;  mgmt_write = 1'b1; end
            S_WR_C:     begin mgmt_address = 6'h05; mgmt_writedata = c_word; mgmt_write = 1'b1; end
`ifdef PLL_RECFG_READBACK_EN
            S_RD_CHK:   begin mgmt_address = rd_addr; rd_strobe = 1'b1; end
`endif
            S_WR_START: begin mgmt_address = 6'h02; mgmt_writedata = 32'd1;  mgmt_write = 1'b1; end
            default:    ;
        endcase
    end

    // Two-flop synchroniser for the asynchronous lock indicator
    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    // Sequencer: write the profile, start reconfig, then qualify lock or time out
    always_ff @(posedge refclk) begin
        if (rst) begin
            state       <= S_IDLE;
            prof_q      <= '0;
            cur_profile <= '0;
            c_idx       <= 5'd0;
            stable_cnt  <= 32'd0;
            timeout_cnt <= 32'd0;
`ifdef PLL_RECFG_READBACK_EN
            rd_idx      <= 2'd0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    c_idx       <= 5'd0;
                    stable_cnt  <= 32'd0;
                    timeout_cnt <= 32'd0;
`ifdef PLL_RECFG_READBACK_EN
                    rd_idx      <= 2'd0;
`endif
                    if (req_valid) begin
                        if (int'(req_profile) >= NUM_PROFILES) begin
                            state <= S_ERR;
                        end else begin
                            prof_q <= req_profile;
                            state  <= S_WR_MODE;
                        end
                    end
                end
                S_WR_MODE: if (!mgmt_waitrequest) state <= S_WR_N;
                S_WR_N:    if (!mgmt_waitrequest) state <= S_WR_M;
                S_WR_M:    if (!mgmt_waitrequest) state <= S_WR_K;
                S_WR_K:    if (!mgmt_waitrequest) state <= S_WR_C;
                S_WR_C: begin
                    if (!mgmt_waitrequest) begin
                        if (last_clock) begin
`ifdef PLL_RECFG_READBACK_EN
                            state <= S_RD_CHK;
`else
                            state <= S_WR_START;
`endif
                        end else begin
                            c_idx <= c_idx + 5'd1;
                        end
                    end
                end
`ifdef PLL_RECFG_READBACK_EN
                S_RD_CHK: begin
                    if (!mgmt_waitrequest) begin
                        if (mgmt_readdata != rd_exp) state <= S_ERR;
                        else if (rd_idx == 2'd2)    state <= S_WR_START;
                        else                        rd_idx <= rd_idx + 2'd1;
                    end
                end
`endif
                S_WR_START: begin
                    if (!mgmt_waitrequest) begin
                        state       <= S_WAIT_LOCK;
                        stable_cnt  <= 32'd0;
                        timeout_cnt <= 32'd0;
                    end
                end
                S_WAIT_LOCK: begin
                    stable_cnt  <= lock_sync ? stable_inc : 32'd0;
                    timeout_cnt <= timeout_inc;
                    if (lock_sync && (stable_inc == 32'(LOCK_STABLE))) begin
                        state       <= S_DONE;
                        cur_profile <= prof_q;
                    end else if (timeout_inc == 32'(LOCK_TIMEOUT)) begin
                        state <= S_ERR;
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb_pll_reconfig_seq
// Self-checking bench for pll_reconfig_seq with 3 profiles and 2 clocks.
// Expected bus transactions are built from the profile tables; expected done/err
// cycles are derived from the lock waveform the bench itself drives.
module tb_pll_reconfig_seq;

    localparam int NC = 2;
    localparam int NP = 3;
    localparam int PW = 2;
    localparam int LS = 16;
    localparam int LT = 100;
    localparam logic [16*NP-1:0]    N_TAB = {16'h0101, 16'h0403, 16'h0202};
    localparam logic [16*NP-1:0]    M_TAB = {16'h1c1c, 16'h2020, 16'h3838};
    localparam logic [32*NP-1:0]    K_TAB = {32'h1234_5678, 32'd0, 32'd214748365};
    localparam logic [16*NP*NC-1:0] C_TAB = {16'h0706, 16'h0101, 16'h0a0a, 16'h0504, 16'h0303, 16'h0202};

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [PW-1:0] req_profile = '0;
    logic          req_ready, busy, done, err;
    logic [PW-1:0] cur_profile;
    logic          pll_locked = 1'b0;
    logic [5:0]    mgmt_address;
    logic [31:0]   mgmt_writedata;
    logic          mgmt_write, mgmt_read;
    logic [31:0]   mgmt_readdata = 32'h0;
    logic          mgmt_waitrequest = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int wait_mode = 0;
    int stall_left = 0;
    bit corrupt = 1'b0;
    int model_cur = 0;

    logic [37:0] wr_q[$];
    logic [37:0] exp_q[$];
    logic [31:0] regs[64];
    bit   start_seen = 1'b0;
    int   start_cyc = 0, done_count = 0, done_cyc = 0, err_count = 0, err_cyc = 0;
    int   strobe_cnt = 0, m_cycles = 0, proto_err = 0;
    bit   prev_stall = 1'b0;
    logic [5:0]  prev_addr;
    logic [31:0] prev_data;
    logic        prev_wr, prev_rd;

    pll_reconfig_seq #(
        .NUM_CLOCKS(NC), .NUM_PROFILES(NP),
        .N_TABLE(N_TAB), .M_TABLE(M_TAB), .K_TABLE(K_TAB), .C_TABLE(C_TAB),
        .LOCK_STABLE(LS), .LOCK_TIMEOUT(LT)
    ) dut (
        .refclk(refclk), .rst(rst), .req_valid(req_valid), .req_profile(req_profile),
        .req_ready(req_ready), .busy(busy), .done(done), .err(err), .cur_profile(cur_profile),
        .pll_locked(pll_locked), .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_write(mgmt_write), .mgmt_read(mgmt_read), .mgmt_readdata(mgmt_readdata),
        .mgmt_waitrequest(mgmt_waitrequest)
    );

    always #5 refclk = ~refclk;

    // Cycle counter: value n during the n-th clock period
    initial forever begin
        @(posedge refclk);
        cyc++;
    end

    // Slave model: stall policy and read data from the register image
    initial forever begin
        @(posedge refclk); #1;
        case (wait_mode)
            0: mgmt_waitrequest = 1'b0;
            1: mgmt_waitrequest = ($urandom_range(0, 2) == 0);
            default: begin
                if (mgmt_write && mgmt_address == 6'h04 && stall_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    mgmt_waitrequest = 1'b0;
                end
            end
        endcase
        mgmt_readdata = regs[mgmt_address] ^ ((corrupt && mgmt_address == 6'h04) ? 32'h0000_0100 : 32'h0);
    end

    // Bus monitor: records completed transfers, pulses and protocol violations
    always @(negedge refclk) begin
        if (mgmt_write && mgmt_read) proto_err++;
        if (prev_stall && (mgmt_address !== prev_addr || mgmt_writedata !== prev_data ||
                           mgmt_write !== prev_wr || mgmt_read !== prev_rd)) proto_err++;
        prev_stall = (mgmt_write || mgmt_read) && mgmt_waitrequest && !rst;
        prev_addr = mgmt_address; prev_data = mgmt_writedata; prev_wr = mgmt_write; prev_rd = mgmt_read;
        if (mgmt_write || mgmt_read) strobe_cnt++;
        if (mgmt_write && mgmt_address == 6'h04) m_cycles++;
        if (mgmt_write && !mgmt_waitrequest) begin
            wr_q.push_back({mgmt_address, mgmt_writedata});
            regs[mgmt_address] = mgmt_writedata;
            if (mgmt_address == 6'h02) begin start_seen = 1'b1; start_cyc = cyc; end
        end
        if (done) begin done_count++; done_cyc = cyc; end
        if (err)  begin err_count++;  err_cyc  = cyc; end
    end

    function automatic logic [31:0] pll_word(input logic [15:0] hl);
        return {15'b0, (hl == 16'h0101), hl};
    endfunction

    task automatic build_expected(input int p);
        logic [15:0] hl;
        exp_q.delete();
        exp_q.push_back({6'h00, 32'd0});
        exp_q.push_back({6'h03, pll_word(N_TAB[16*p +: 16])});
        exp_q.push_back({6'h04, pll_word(M_TAB[16*p +: 16])});
        exp_q.push_back({6'h07, K_TAB[32*p +: 32]});
        for (int c = 0; c < NC; c++) begin
            hl = C_TAB[16*(p*NC + c) +: 16];
            exp_q.push_back({6'h05, 9'b0, 5'(c), 1'b0, (hl == 16'h0101), hl});
        end
        exp_q.push_back({6'h02, 32'd1});
    endtask

    task automatic tick();
        @(posedge refclk); #1;
    endtask

    task automatic clear_monitor();
        wr_q.delete(); start_seen = 1'b0; done_count = 0; err_count = 0;
        strobe_cnt = 0; m_cycles = 0; proto_err = 0;
    endtask

    task automatic issue_request(input int p, output int req_cyc);
        tick();
        req_valid = 1'b1; req_profile = PW'(p); req_cyc = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (start_seen) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_profile(input int p, input bit glitch, input bit poke_busy, input string tag);
        int rc, e, rise, exp_done;
        bit ok;
        pll_locked = 1'b0;
        build_expected(p);
        clear_monitor();
        issue_request(p, rc);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (poke_busy && i == 2) begin req_valid = 1'b1; req_profile = PW'((p + 1) % NP); end
            if (i == 4) req_valid = 1'b0;
            if (start_seen) begin ok = 1'b1; break; end
        end
        req_valid = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s start_wait got timeout want start write", tag); end
        e = start_cyc + 1;
        pll_locked = 1'b1; rise = cyc;
        if (glitch) begin
            repeat (10) tick();
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1; rise = cyc;
        end
        exp_done = (((rise + 2) > e) ? (rise + 2) : e) + LS;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done_count > 0 || err_count > 0) begin ok = 1'b1; break; end
        end
        repeat (4) tick();
        if (done_count == 1 && err_count == 0) model_cur = p;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL %s done_wait got timeout want pulse", tag); end
        n_checks++;
        if (done_cyc !== exp_done) begin n_fail++; $display("FAIL %s done_cycle got %0d want %0d", tag, done_cyc, exp_done); end
        n_checks++;
        if (done_count !== 1) begin n_fail++; $display("FAIL %s done_count got %0d want 1", tag, done_count); end
        n_checks++;
        if (err_count !== 0) begin n_fail++; $display("FAIL %s err_count got %0d want 0", tag, err_count); end
        n_checks++;
        if (cur_profile !== PW'(p)) begin n_fail++; $display("FAIL %s cur_profile got %0d want %0d", tag, cur_profile, p); end
        n_checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle got busy=%b ready=%b want 0/1", tag, busy, req_ready); end
        n_checks++;
        if (proto_err !== 0) begin n_fail++; $display("FAIL %s avalon_protocol got %0d violations want 0", tag, proto_err); end
        n_checks++;
        if (wr_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL %s xfer_count got %0d want %0d", tag, wr_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s xfer[%0d] got addr=%h data=%h want addr=%h data=%h", tag, i,
                         wr_q[i][37:32], wr_q[i][31:0], exp_q[i][37:32], exp_q[i][31:0]);
            end
        end
    endtask

    task automatic check_bad_profile(input string tag);
        int rc;
        clear_monitor();
        issue_request(NP, rc);
        repeat (4) tick();
        n_checks++;
        if (err_count !== 1 || err_cyc !== rc + 1) begin
            n_fail++; $display("FAIL %s err_pulse got count=%0d cycle=%0d want 1 at %0d", tag, err_count, err_cyc, rc + 1);
        end
        n_checks++;
        if (strobe_cnt !== 0) begin n_fail++; $display("FAIL %s mgmt_strobes got %0d want 0", tag, strobe_cnt); end
        n_checks++;
        if (cur_profile !== PW'(model_cur)) begin n_fail++; $display("FAIL %s cur_profile got %0d want %0d", tag, cur_profile, model_cur); end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; pll_locked = 1'b0;
        repeat (3) tick();
        @(negedge refclk);
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", req_ready); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++;
        if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got done=%b err=%b want 0/0", done, err); end
        n_checks++;
        if (cur_profile !== '0) begin n_fail++; $display("FAIL reset_cur_profile got %0d want 0", cur_profile); end
        n_checks++;
        if (mgmt_write !== 1'b0 || mgmt_read !== 1'b0) begin n_fail++; $display("FAIL reset_strobes got w=%b r=%b want 0/0", mgmt_write, mgmt_read); end
        n_checks++;
        if (mgmt_address !== 6'h0 || mgmt_writedata !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus got addr=%h data=%h want 0/0", mgmt_address, mgmt_writedata);
        end
        tick();
        rst = 1'b0; model_cur = 0;
    endtask

    task automatic test_program();
        wait_mode = 0;
        run_profile(1, 1'b0, 1'b1, "program_p1");
        n_checks++;
        if (wr_q.size() < 7 || wr_q[4][22:18] !== 5'd0 || wr_q[5][22:18] !== 5'd1) begin
            n_fail++; $display("FAIL c_index_bits got %h,%h want 0,1", wr_q[4][22:18], wr_q[5][22:18]);
        end
    endtask

    task automatic test_stall_m();
        wait_mode = 2; stall_left = 3;
        run_profile(0, 1'b0, 1'b0, "stall_m");
        n_checks++;
        if (m_cycles !== 4) begin n_fail++; $display("FAIL stall_m_hold got %0d cycles want 4", m_cycles); end
        wait_mode = 0;
    endtask

    task automatic test_lock_glitch();
        wait_mode = 0;
        run_profile(1, 1'b1, 1'b0, "lock_glitch");
    endtask

    task automatic test_timeout();
        int rc, e;
        bit ok;
        wait_mode = 0; pll_locked = 1'b0;
        clear_monitor();
        issue_request(2, rc);
        wait_start(ok);
        e = start_cyc + 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (err_count > 0) break;
        end
        repeat (3) tick();
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL timeout_start got timeout want start write"); end
        n_checks++;
        if (err_count !== 1 || err_cyc !== e + LT) begin
            n_fail++; $display("FAIL timeout_err got count=%0d cycle=%0d want 1 at %0d", err_count, err_cyc, e + LT);
        end
        n_checks++;
        if (done_count !== 0) begin n_fail++; $display("FAIL timeout_done got %0d want 0", done_count); end
        n_checks++;
        if (cur_profile !== PW'(model_cur)) begin n_fail++; $display("FAIL timeout_cur_profile got %0d want %0d", cur_profile, model_cur); end
    endtask

    task automatic test_reset_mid();
        int rc;
        bit ok;
        wait_mode = 0; pll_locked = 1'b0;
        clear_monitor();
        issue_request(2, rc);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge refclk);
            if (mgmt_write && mgmt_address == 6'h05) begin ok = 1'b1; break; end
        end
        rst = 1'b1;
        model_cur = 0;
        @(negedge refclk);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rst_mid_wrc got timeout want C write"); end
        n_checks++;
        if (mgmt_write !== 1'b0 || mgmt_read !== 1'b0) begin n_fail++; $display("FAIL rst_mid_strobes got w=%b r=%b want 0/0", mgmt_write, mgmt_read); end
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got ready=%b busy=%b want 1/0", req_ready, busy); end
        n_checks++;
        if (cur_profile !== PW'(model_cur)) begin n_fail++; $display("FAIL rst_mid_cur_profile got %0d want %0d", cur_profile, model_cur); end
        @(posedge refclk); #1;
        rst = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (start_seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_start got start write want none"); end
    endtask

    task automatic test_random();
        int p;
        for (int it = 0; it < 5; it++) begin
            p = $urandom_range(0, NP);
            wait_mode = 1;
            if (p == NP) check_bad_profile("rand_bad");
            else run_profile(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end
        wait_mode = 0;
    endtask

`ifdef PLL_RECFG_READBACK_EN
    task automatic test_readback_corrupt();
        int rc;
        wait_mode = 0; pll_locked = 1'b0; corrupt = 1'b1;
        clear_monitor();
        issue_request(0, rc);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (err_count > 0) break;
        end
        repeat (3) tick();
        corrupt = 1'b0;
        n_checks++;
        if (err_count !== 1) begin n_fail++; $display("FAIL readback_err got %0d want 1", err_count); end
        n_checks++;
        if (start_seen !== 1'b0) begin n_fail++; $display("FAIL readback_start got start write want none"); end
        n_checks++;
        if (cur_profile !== PW'(model_cur)) begin n_fail++; $display("FAIL readback_cur_profile got %0d want %0d", cur_profile, model_cur); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) regs[i] = 32'h0;
        test_reset();
        test_program();
        test_stall_m();
        test_lock_glitch();
        test_timeout();
        check_bad_profile("bad_profile");
        test_reset_mid();
        test_random();
`ifdef PLL_RECFG_READBACK_EN
        test_readback_corrupt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound so a stuck sequencer cannot hang the run
    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish within bound");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
